// File: rtl/chan_mux_rr.sv
// chan_mux_rr: N-channel to one multiplexer with a registered output stage.
// Mode 0 arbitrates round-robin from a rotating pointer. Mode 1 passes a single
// fixed channel chosen by sel.
module chan_mux_rr #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 8,
    localparam int unsigned S = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [S-1:0]   sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [S-1:0]   out_chan,
    input  logic           out_ready
);

    logic [S-1:0] ptr;
    logic         load_en;
    logic         rr_found;
    logic [S-1:0] rr_idx;
    logic [S-1:0] cand;
    logic         grant_vld;
    logic [S-1:0] grant_idx;

    // The output register can take a new beat when it is empty or being drained.
    assign load_en = !out_valid || out_ready;

    // Round-robin search: first valid channel at or above ptr, wrapping past N-1.
    // N is a power of two, so the S-bit add provides the wrap.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + S'(k);
            if (!rr_found && in_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Grant selection. Fixed mode ignores every channel other than sel.
    always_comb begin
        if (mode) begin
            grant_vld = in_valid[sel];
            grant_idx = sel;
        end else begin
            grant_vld = rr_found;
            grant_idx = rr_idx;
        end
    end

    // Accept strobe: one-hot on the granted channel, suppressed under reset.
    always_comb begin
        in_ready = '0;
        if (grant_vld && load_en && !rst) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant_idx*W +: W];
                out_chan  <= grant_idx;
                if (!mode) begin
                    ptr <= grant_idx + S'(1);
                end
            end else begin
                // Data and channel hold; only the valid flag drops.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed testbench for chan_mux_rr with N=16, W=8.
module tb_chan_mux_rr;

    localparam int N = 16;
    localparam int W = 8;
    localparam int S = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [S-1:0]   sel;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_chan;
    logic           out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    logic [W-1:0] xfer_last = '0;
    int xfer_base;

    chan_mux_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count output transfers seen at each rising edge.
    always @(posedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            xfer_cnt  = xfer_cnt + 1;
            xfer_last = out_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        in_valid  = 16'hFFFF;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(i + 8'h10);

        // Reset state, with every channel requesting.
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_chan",  32'(out_chan),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        @(negedge clk);
        in_valid = '0;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("idle_in_ready",  32'(in_ready),  32'd0);
            @(negedge clk);
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_out_data",  32'(out_data),  32'd0);
        end

        // Round-robin fairness across all channels.
        in_valid = 16'hFFFF;
        #1;
        check("rr_in_ready_first", 32'(in_ready), 32'h0001);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check("rr_out_valid", 32'(out_valid), 32'd1);
            check("rr_out_chan",  32'(out_chan),  32'(i % 16));
            check("rr_out_data",  32'(out_data),  32'(8'h10 + (i % 16)));
        end
        in_valid = '0;
        @(negedge clk);
        check("rr_drain_valid", 32'(out_valid), 32'd0);

        // Reset pulse to return the pointer to 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Sparse channels 3 and 14 with wrap.
        in_valid = 16'h4008;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sparse_chan", 32'(out_chan), (i % 2 == 0) ? 32'd3 : 32'd14);
            check("sparse_data", 32'(out_data), (i % 2 == 0) ? 32'h13 : 32'h1E);
        end
        in_valid = '0;
        @(negedge clk);
        check("sparse_drain_valid", 32'(out_valid), 32'd0);
        check("sparse_hold_chan",   32'(out_chan),  32'd14);
        @(negedge clk);
        @(negedge clk);

        // Pointer held at 15 through idle cycles.
        in_valid = 16'hFFFF;
        #1;
        check("ptr_hold_ready", 32'(in_ready), 32'h8000);
        @(negedge clk);
        check("ptr_hold_chan", 32'(out_chan), 32'd15);
        @(negedge clk);
        check("ptr_wrap_chan", 32'(out_chan), 32'd0);
        in_valid = '0;
        @(negedge clk);

        // Backpressure with a beat from channel 5 held.
        in_data[5*W +: W] = 8'hA5;
        in_valid = 16'h0020;
        @(negedge clk);
        check("bp_load_chan", 32'(out_chan), 32'd5);
        check("bp_load_data", 32'(out_data), 32'hA5);
        out_ready = 1'b0;
        in_valid  = 16'hFFFF;
        xfer_base = xfer_cnt;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  32'(out_data),  32'hA5);
            check("bp_out_chan",  32'(out_chan),  32'd5);
            @(negedge clk);
        end
        check("bp_no_xfer", 32'(xfer_cnt - xfer_base), 32'd0);
        out_ready = 1'b1;
        in_valid  = '0;
        @(negedge clk);
        check("bp_one_xfer",   32'(xfer_cnt - xfer_base), 32'd1);
        check("bp_xfer_data",  32'(xfer_last), 32'hA5);
        check("bp_after_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("bp_still_one", 32'(xfer_cnt - xfer_base), 32'd1);

        // Fixed mode on channel 7; pointer sits at 6.
        mode     = 1'b1;
        sel      = 4'd7;
        in_valid = 16'hFFFF;
        #1;
        check("fix_in_ready", 32'(in_ready), 32'h0080);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("fix_chan", 32'(out_chan), 32'd7);
            check("fix_data", 32'(out_data), 32'h17);
        end

        // Fixed mode with the selected channel idle.
        in_valid = 16'hFF7F;
        #1;
        check("fix_idle_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("fix_idle_valid", 32'(out_valid), 32'd0);
        check("fix_idle_chan",  32'(out_chan),  32'd7);
        check("fix_idle_data",  32'(out_data),  32'h17);

        // Back to round-robin: pointer unchanged by fixed mode.
        mode     = 1'b0;
        in_valid = 16'hFFFF;
        #1;
        check("rr_resume_ready", 32'(in_ready), 32'h0040);
        @(negedge clk);
        check("rr_resume_chan", 32'(out_chan), 32'd6);
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset between edges during a full stream.
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data",  32'(out_data),  32'd0);
        check("arst_chan",  32'(out_chan),  32'd0);
        check("arst_ready", 32'(in_ready),  32'd0);
        xfer_base = xfer_cnt;
        @(negedge clk);
        check("arst_no_xfer", 32'(xfer_cnt - xfer_base), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("arst_first_valid", 32'(out_valid), 32'd1);
        check("arst_first_chan",  32'(out_chan),  32'd0);
        check("arst_first_data",  32'(out_data),  32'h10);
        @(negedge clk);
        check("arst_second_chan", 32'(out_chan), 32'd1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/chan_mux_rr.md
CHAN_MUX_RR -- requirements
Module: chan_mux_rr

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the number of input channels (N >= 2, power of two).
REQ-002 The block SHALL have parameter W, default 8, giving the data width per channel.
REQ-003 The block SHALL derive local parameter S = log2(N), the channel-index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, N bits: per-channel data-valid flags.
REQ-007 The block SHALL have port in_data, input, N*W bits: channel i occupies bits [i*W+W-1 : i*W].
REQ-008 The block SHALL have port in_ready, output, N bits: per-channel accept strobes.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 selects round-robin, 1 selects fixed channel.
REQ-010 The block SHALL have port sel, input, S bits: the channel index used when mode=1.
REQ-011 The block SHALL have port out_valid, output, 1 bit: output register holds a beat.
REQ-012 The block SHALL have port out_data, output, W bits: registered selected data.
REQ-013 The block SHALL have port out_chan, output, S bits: source channel index of out_data.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-015 A transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both 1 on a rising clk edge; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-016 load_en SHALL be 1 when the output register is free: (!out_valid || out_ready).
REQ-017 In mode=0, the grant SHALL be the first channel with in_valid=1, searching upward from the round-robin pointer ptr with wrap from N-1 to 0.
REQ-018 In mode=1, the grant SHALL be sel if in_valid[sel]=1; otherwise there SHALL be no grant, and other channels are ignored.
REQ-019 in_ready SHALL be combinational: in_ready[g]=load_en for the granted channel g, and 0 for every other channel; at most one bit SHALL be set.
REQ-020 On a grant with load_en=1, the next edge SHALL load out_data<=in_data[g], out_chan<=g, out_valid<=1. Latency is 1 cycle; full throughput is one beat per cycle while out_ready=1.
REQ-021 When load_en=1 and there is no grant, the next edge SHALL set out_valid<=0; out_data and out_chan SHALL hold their values.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL remain stable and all in_ready SHALL be 0.
REQ-023 In mode=0, ptr SHALL update to (g+1) mod N on each channel transfer; with no transfer, ptr SHALL hold.
REQ-024 In mode=1, ptr SHALL hold.
REQ-025 A change of mode or sel SHALL take effect on the same cycle's grant decision and SHALL NOT disturb a beat already held in the output register.
REQ-026 When g=N-1, ptr SHALL wrap to 0.

Reset
REQ-027 While rst=1, the block SHALL force out_valid=0, out_data=0, out_chan=0 and ptr=0 immediately, independent of clk.
REQ-028 While rst=1, all in_ready SHALL be 0.
REQ-029 Reset asserted mid-transfer SHALL discard the held beat without generating any output transfer.
REQ-030 Operation SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-031 Reset case: assert rst, then release it with in_valid=0 -> out_valid=0, out_data=0, out_chan=0, and in_ready=0 for all cycles.
REQ-032 Round-robin fairness: mode=0, N=16, W=8, in_valid=16'hFFFF, in_data channel i = i+8'h10, out_ready=1 -> out_chan sequence 0,1,...,15,0, with out_data=8'h10..8'h1F, one beat per cycle.
REQ-033 Sparse channels and wrap: mode=0, only channels 3 and 14 valid, ptr=0 -> grants are 3, 14, 3, 14.
REQ-034 Pointer hold when idle: after a grant to 14, idle cycles leave ptr=15.
REQ-035 Backpressure: out_ready=0 for 3 cycles with a beat from channel 5 = 8'hA5 held -> out_data stays 8'hA5, out_chan stays 5, and in_ready=0 for those 3 cycles. When out_ready returns to 1, exactly one transfer of 8'hA5 occurs.
REQ-036 Fixed mode: mode=1, sel=7, in_valid=16'hFFFF -> only channel 7 is granted each cycle and ptr is unchanged.
REQ-037 Fixed mode with sel invalid: mode=1, sel=7, in_valid[7]=0 -> out_valid=0 after the next edge.
REQ-038 Asynchronous reset mid-stream: assert rst between clock edges during a mode=0 full-throughput stream -> out_valid=0 immediately. After release, the first grant is channel 0.
